// File: rtl/dmem_port_arbiter_if.sv
// Requester and byte-memory signals of the two-port data memory arbiter.
// The arbiter uses the slave modport; requesters and the memory model use master.
interface dmem_port_arbiter_if #(
    parameter int unsigned MADDR_W = 16
);
    logic               r0_req;
    logic               r0_wen;
    logic [63:0]        r0_addr;
    logic [63:0]        r0_wdata;
    logic               r0_done;
    logic               r0_err;
    logic [63:0]        r0_rdata;

    logic               r1_req;
    logic               r1_wen;
    logic [63:0]        r1_addr;
    logic [63:0]        r1_wdata;
    logic               r1_done;
    logic               r1_err;
    logic [63:0]        r1_rdata;

    logic [MADDR_W-1:0] mem_addr;
    logic               mem_ren;
    logic               mem_wen;
    logic [7:0]         mem_wdata;
    logic [7:0]         mem_rdata;

    logic               busy;
    logic               grant_id;

    modport slave (
        input  r0_req, r0_wen, r0_addr, r0_wdata,
        input  r1_req, r1_wen, r1_addr, r1_wdata,
        input  mem_rdata,
        output r0_done, r0_err, r0_rdata,
        output r1_done, r1_err, r1_rdata,
        output mem_addr, mem_ren, mem_wen, mem_wdata,
        output busy, grant_id
    );

    modport master (
        output r0_req, r0_wen, r0_addr, r0_wdata,
        output r1_req, r1_wen, r1_addr, r1_wdata,
        output mem_rdata,
        input  r0_done, r0_err, r0_rdata,
        input  r1_done, r1_err, r1_rdata,
        input  mem_addr, mem_ren, mem_wen, mem_wdata,
        input  busy, grant_id
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing a byte-wide single-port memory between two 64-bit requesters;
// each grant becomes 8 little-endian byte accesses, or an immediate error if out of range.
module dmem_port_arbiter #(
    parameter int unsigned MEM_BYTES = 65536,
    parameter int unsigned MADDR_W   = 16
) (
    input logic               clk,
    input logic               rst,
    dmem_port_arbiter_if.slave bus
);
    localparam logic [63:0] MaxAddr = 64'(MEM_BYTES) - 64'd8;

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 id_q, id_d;
    logic                 wen_q, wen_d;
    logic                 err_q, err_d;
    logic [MADDR_W-1:0]   addr_q, addr_d;
    logic [63:0]          wdata_q, wdata_d;
    logic [2:0]           k_q, k_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [2:0]           rd_idx_q, rd_idx_d;
    logic [63:0]          rbuf_q, rbuf_d;
    logic [63:0]          r0_rdata_q, r0_rdata_d;
    logic [63:0]          r1_rdata_q, r1_rdata_d;

    logic                 gnt;
    logic [63:0]          sel_addr;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        wen_d        = wen_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        k_d          = k_q;
        r0_rdata_d   = r0_rdata_q;
        r1_rdata_d   = r1_rdata_q;
        gnt          = 1'b0;
        sel_addr     = 64'd0;

        // Read bytes land one cycle after issue; byte 7 arrives during StDone.
        rd_vld_d = (state_q == StXfer) && !wen_q;
        rd_idx_d = k_q;
        rbuf_d   = rbuf_q;
        if (rd_vld_q) begin
            rbuf_d[{rd_idx_q, 3'b000} +: 8] = bus.mem_rdata;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.r0_req || bus.r1_req) begin
                    gnt          = (bus.r0_req && bus.r1_req) ? ~last_grant_q : bus.r1_req;
                    sel_addr     = gnt ? bus.r1_addr : bus.r0_addr;
                    id_d         = gnt;
                    last_grant_d = gnt;
                    wen_d        = gnt ? bus.r1_wen : bus.r0_wen;
                    wdata_d      = gnt ? bus.r1_wdata : bus.r0_wdata;
                    addr_d       = sel_addr[MADDR_W-1:0];
                    k_d          = 3'd0;
                    // Full 64-bit compare so high address bits cannot alias into range.
                    err_d        = sel_addr > MaxAddr;
                    state_d      = (sel_addr > MaxAddr) ? StDone : StXfer;
                end
            end
            StXfer: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (err_q || !wen_q) begin
                    if (id_q) r1_rdata_d = err_q ? 64'd0 : rbuf_d;
                    else      r0_rdata_d = err_q ? 64'd0 : rbuf_d;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            wen_q        <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 64'd0;
            k_q          <= 3'd0;
            rd_vld_q     <= 1'b0;
            rd_idx_q     <= 3'd0;
            rbuf_q       <= 64'd0;
            r0_rdata_q   <= 64'd0;
            r1_rdata_q   <= 64'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            wen_q        <= wen_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            k_q          <= k_d;
            rd_vld_q     <= rd_vld_d;
            rd_idx_q     <= rd_idx_d;
            rbuf_q       <= rbuf_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
        end
    end

    logic in_xfer;
    logic in_done;
    assign in_xfer = (state_q == StXfer);
    assign in_done = (state_q == StDone);

    assign bus.mem_ren   = in_xfer && !wen_q;
    assign bus.mem_wen   = in_xfer && wen_q;
    assign bus.mem_addr  = in_xfer ? addr_q + MADDR_W'(k_q) : '0;
    assign bus.mem_wdata = in_xfer ? wdata_q[{k_q, 3'b000} +: 8] : 8'd0;

    assign bus.r0_done  = in_done && !id_q;
    assign bus.r1_done  = in_done && id_q;
    assign bus.r0_err   = in_done && !id_q && err_q;
    assign bus.r1_err   = in_done && id_q && err_q;
    assign bus.r0_rdata = r0_rdata_q;
    assign bus.r1_rdata = r1_rdata_q;

    assign bus.busy     = (state_q != StIdle);
    assign bus.grant_id = (state_q != StIdle) && id_q;
endmodule
